// File: rtl/gf180mcu_osu_sc_gp12t3v3__tie_rel_pkg.sv
// Shared types and constants for the tie-low release sequencer.
package gf180mcu_osu_sc_gp12t3v3__tie_rel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HELD  = 2'd2
  } state_t;

  localparam int N_GROUPS_DEF = 4;
  localparam int DLY_W_DEF    = 8;

  // Group index width; a single group still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_gp12t3v3__tie_rel_cnt.sv
// Loadable gap down-counter; load wins over decrement, and it saturates at zero.
// Zero flag is decoded from the registered count.
module gf180mcu_osu_sc_gp12t3v3__tie_rel_cnt
  import gf180mcu_osu_sc_gp12t3v3__tie_rel_pkg::*;
#(
  parameter int DLY_W = DLY_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DLY_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [DLY_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - DLY_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gf180mcu_osu_sc_gp12t3v3__tie_rel_seq.sv
// Tie-off release sequencer: holds Y low, then on START releases one group per (DLY+1) cycles.
// All outputs registered; START is ignored while a sequence runs or is held.
module gf180mcu_osu_sc_gp12t3v3__tie_rel_seq
  import gf180mcu_osu_sc_gp12t3v3__tie_rel_pkg::*;
#(
  parameter int N_GROUPS = N_GROUPS_DEF,
  parameter int DLY_W    = DLY_W_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                ABORT,
  input  logic [DLY_W-1:0]    DLY,
  output logic [N_GROUPS-1:0] Y,
  output logic                BUSY,
  output logic                DONE
);

  localparam int IW = idx_w(N_GROUPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_GROUPS - 1);
  localparam logic [N_GROUPS-1:0] ONE_HOT0 = N_GROUPS'(1);

  state_t           state;
  logic [DLY_W-1:0] dly_q;
  logic [IW-1:0]    idx;
  logic             cnt_load;
  logic             cnt_dec;
  logic [DLY_W-1:0] cnt_val;
  logic             cnt_zero;

  specify
  endspecify

  // Counter is reloaded on sequence start and on every non-final release.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    if (ABORT) begin
      cnt_load = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            cnt_load = 1'b1;
            cnt_val  = DLY;
          end
        end
        COUNT: begin
          if (!cnt_zero) begin
            cnt_dec = 1'b1;
          end else if (idx != LAST_IDX) begin
            cnt_load = 1'b1;
            cnt_val  = dly_q;
          end
        end
        default: ;
      endcase
    end
  end

  gf180mcu_osu_sc_gp12t3v3__tie_rel_cnt #(
    .DLY_W (DLY_W)
  ) u_cnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      dly_q <= '0;
      idx   <= '0;
      Y     <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else if (ABORT) begin
      state <= IDLE;
      idx   <= '0;
      Y     <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            state <= COUNT;
            dly_q <= DLY;
            idx   <= '0;
            BUSY  <= 1'b1;
          end
        end
        COUNT: begin
          if (cnt_zero) begin
            Y <= Y | (ONE_HOT0 << idx);
            if (idx == LAST_IDX) begin
              state <= HELD;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        HELD: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__tie_rel_seq.sv
// Bench for the release sequencer: directed scenarios plus random traffic against a schedule model.
module tb_gf180mcu_osu_sc_gp12t3v3__tie_rel_seq;

  logic       clk;
  logic       rst;
  logic       start0, abort0, start1, abort1;
  logic [7:0] dly0, dly1;
  logic [3:0] y0;
  logic [0:0] y1;
  logic       busy0, done0, busy1, done1;

  int n_chk;
  int n_fail;
  int edge_n;

  // Model state: a sequence is a start edge and a gap; the released count follows arithmetically.
  bit act [2];
  int t0  [2];
  int dd  [2];
  int ng  [2];

  gf180mcu_osu_sc_gp12t3v3__tie_rel_seq #(.N_GROUPS(4), .DLY_W(8)) u_dut0 (
    .CLK(clk), .RST(rst), .START(start0), .ABORT(abort0), .DLY(dly0),
    .Y(y0), .BUSY(busy0), .DONE(done0)
  );

  gf180mcu_osu_sc_gp12t3v3__tie_rel_seq #(.N_GROUPS(1), .DLY_W(8)) u_dut1 (
    .CLK(clk), .RST(rst), .START(start1), .ABORT(abort1), .DLY(dly1),
    .Y(y1), .BUSY(busy1), .DONE(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  function automatic int released(input int i);
    int k;
    if (!act[i]) return 0;
    k = (edge_n - t0[i]) / (dd[i] + 1);
    return (k > ng[i]) ? ng[i] : k;
  endfunction

  task automatic model_upd(input int i, input bit r, input bit s, input bit a, input int d);
    if (r || a) begin
      act[i] = 1'b0;
    end else if (!act[i] && s) begin
      act[i] = 1'b1;
      t0[i]  = edge_n;
      dd[i]  = d;
    end
  endtask

  task automatic tick();
    int k0, k1;
    @(posedge clk);
    edge_n++;
    model_upd(0, rst, start0, abort0, int'(dly0));
    model_upd(1, rst, start1, abort1, int'(dly1));
    #1;
    k0 = released(0);
    k1 = released(1);
    chk("m_y0",    32'(y0),    (32'd1 << k0) - 32'd1);
    chk("m_busy0", 32'(busy0), 32'(act[0] && (k0 < ng[0])));
    chk("m_done0", 32'(done0), 32'(act[0] && (k0 == ng[0])));
    chk("m_y1",    32'(y1),    (32'd1 << k1) - 32'd1);
    chk("m_busy1", 32'(busy1), 32'(act[1] && (k1 < ng[1])));
    chk("m_done1", 32'(done1), 32'(act[1] && (k1 == ng[1])));
  endtask

  task automatic abort_both();
    abort0 = 1'b1;
    abort1 = 1'b1;
    tick();
    abort0 = 1'b0;
    abort1 = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; edge_n = 0;
    ng[0] = 4; ng[1] = 1;
    for (int i = 0; i < 2; i++) begin act[i] = 1'b0; t0[i] = 0; dd[i] = 0; end
    rst = 1'b1; start0 = 1'b0; abort0 = 1'b0; dly0 = '0;
    start1 = 1'b0; abort1 = 1'b0; dly1 = '0;

    tick();
    tick();
    chk("rst_y0", 32'(y0), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_dlyq0", 32'(u_dut0.dly_q), 32'd0);
    rst = 1'b0;
    tick();

    // DLY=3 baseline
    for (int r = 0; r <= 17; r++) begin
      start0 = (r == 0); dly0 = 8'd3;
      tick();
      if (r == 0) chk("s1_busy_e0", 32'(busy0), 32'd1);
      if (r == 3) chk("s1_y_e3", 32'(y0), 32'h0);
      if (r == 4) chk("s1_y_e4", 32'(y0), 32'h1);
      if (r == 8) chk("s1_y_e8", 32'(y0), 32'h3);
      if (r == 12) chk("s1_y_e12", 32'(y0), 32'h7);
      if (r == 16) begin
        chk("s1_y_e16", 32'(y0), 32'hf);
        chk("s1_done_e16", 32'(done0), 32'd1);
        chk("s1_busy_e16", 32'(busy0), 32'd0);
      end
    end
    start0 = 1'b0;
    abort_both();

    // DLY=0: one group per cycle
    for (int r = 0; r <= 5; r++) begin
      start0 = (r == 0); dly0 = 8'd0;
      tick();
      if (r == 1) chk("s2_y_e1", 32'(y0), 32'h1);
      if (r == 3) chk("s2_y_e3", 32'(y0), 32'h7);
      if (r == 4) chk("s2_done_e4", 32'(done0), 32'd1);
    end
    start0 = 1'b0;
    abort_both();

    // ABORT mid-sequence then restart with DLY=1
    for (int r = 0; r <= 12; r++) begin
      start0 = (r == 0) || (r == 7);
      dly0   = (r == 7) ? 8'd1 : 8'd3;
      abort0 = (r == 6);
      tick();
      if (r == 5) chk("s3_y_e5", 32'(y0), 32'h1);
      if (r == 6) begin
        chk("s3_y_abort", 32'(y0), 32'h0);
        chk("s3_busy_abort", 32'(busy0), 32'd0);
      end
      if (r == 8) chk("s3_y_e8", 32'(y0), 32'h0);
      if (r == 9) chk("s3_y_e9", 32'(y0), 32'h1);
    end
    start0 = 1'b0; abort0 = 1'b0;
    abort_both();

    // START pulses and DLY changes during a running sequence are ignored
    for (int r = 0; r <= 17; r++) begin
      start0 = (r == 0) || (r == 2) || (r == 5);
      dly0   = (r == 0) ? 8'd3 : ((r == 2) ? 8'd9 : 8'd0);
      tick();
      if (r == 7) chk("s4_y_e7", 32'(y0), 32'h1);
      if (r == 8) chk("s4_y_e8", 32'(y0), 32'h3);
      if (r == 12) chk("s4_y_e12", 32'(y0), 32'h7);
      if (r == 16) chk("s4_y_e16", 32'(y0), 32'hf);
    end
    start0 = 1'b0;
    abort_both();

    // RST mid-sequence with START held, then a fresh start
    for (int r = 0; r <= 14; r++) begin
      rst    = (r == 9);
      start0 = (r == 0) || (r == 9) || (r == 10);
      dly0   = (r == 10) ? 8'd2 : 8'd3;
      tick();
      if (r == 9) begin
        chk("s5_y_rst", 32'(y0), 32'h0);
        chk("s5_busy_rst", 32'(busy0), 32'd0);
        chk("s5_dlyq_rst", 32'(u_dut0.dly_q), 32'd0);
      end
      if (r == 10) chk("s5_busy_e10", 32'(busy0), 32'd1);
      if (r == 13) chk("s5_y_e13", 32'(y0), 32'h1);
    end
    rst = 1'b0; start0 = 1'b0;
    abort_both();

    // N_GROUPS=1 with the longest gap, then ABORT+START together in HELD
    for (int r = 0; r <= 260; r++) begin
      start1 = (r == 0) || (r == 258);
      abort1 = (r == 258);
      dly1   = 8'd255;
      tick();
      if (r == 255) begin
        chk("s6_y_e255", 32'(y1), 32'h0);
        chk("s6_busy_e255", 32'(busy1), 32'd1);
      end
      if (r == 256) begin
        chk("s6_y_e256", 32'(y1), 32'h1);
        chk("s6_done_e256", 32'(done1), 32'd1);
      end
      if (r == 258) chk("s6_y_abort", 32'(y1), 32'h0);
      if (r == 260) chk("s6_busy_norestart", 32'(busy1), 32'd0);
    end
    start1 = 1'b0; abort1 = 1'b0;

    // Random traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom % 300) == 0;
      start0 = ($urandom % 6) == 0;
      abort0 = ($urandom % 50) == 0;
      dly0   = (($urandom % 10) == 0) ? 8'($urandom % 40) : 8'($urandom % 4);
      start1 = ($urandom % 5) == 0;
      abort1 = ($urandom % 30) == 0;
      dly1   = 8'($urandom % 8);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gf180mcu_osu_sc_gp12t3v3__tie_rel_seq.md
# gf180mcu_osu_sc_gp12t3v3__tie_rel_seq

Tie-off release sequencer for the gp12t3v3 library's tie-low cells. After reset it holds a bank of N_GROUPS outputs at logic 0, the same constant a tie-low cell drives. On START it releases them to 1 one group at a time, with a programmable gap between groups, so downstream enables and isolation controls come up in a fixed staggered order. It sits between the chip-level bring-up logic and the blocks whose enables would otherwise be hard-tied low.

## Interface
- N_GROUPS, 4: number of release groups; legal range 1..16.
- DLY_W, 8: width of the gap counter.

- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- START  input  1  one-cycle request to begin a release sequence; honoured only in IDLE.
- ABORT  input  1  force all groups low and return to IDLE.
- DLY  input  DLY_W  gap in cycles between group releases; sampled only when START is accepted.
- Y  output  N_GROUPS  registered group outputs; 0 = tied low, 1 = released.
- BUSY  output  1  high while a sequence is in progress.
- DONE  output  1  high while all groups are released.

## Operation
- States:
  - IDLE: Y=0, BUSY=0, DONE=0.
  - COUNT: BUSY=1.
  - HELD: Y all 1, DONE=1.
- Registers:
  - dly_q (DLY_W bits)
  - cnt (DLY_W bits)
  - idx (clog2(N_GROUPS) bits, minimum 1)
- IDLE with START=1: dly_q<=DLY, cnt<=DLY, idx<=0, go to COUNT.
- COUNT with cnt!=0: cnt<=cnt-1.
- COUNT with cnt==0:
  - Y[idx]<=1.
  - If idx==N_GROUPS-1, go to HELD.
  - Otherwise idx<=idx+1 and cnt<=dly_q.
- HELD: remain there until ABORT.
- Y bits are only ever set in index order 0..N-1. Once set, a bit is cleared only by ABORT or RST.
- ABORT in any state: Y<=0, go to IDLE.
- Priority: RST > ABORT > START. START together with ABORT leaves the block in IDLE and does not start a sequence.
- START in COUNT or HELD is ignored. DLY changes during a sequence are ignored.
- The counter never wraps: it is reloaded from dly_q at 0 and never decremented below 0.

## Timing
- All outputs are registered, with no combinational input-to-output paths.
- Reset values: Y=0, BUSY=0, DONE=0, state IDLE, cnt=0, idx=0, dly_q=0.
- START is sampled at edge 0, giving BUSY=1 after edge 0.
- Y[k] rises after edge (k+1)·(D+1), where D is the sampled DLY.
- D=0 gives one group per cycle: Y[k] rises after edge k+1.
- DONE rises and BUSY falls on the same edge that sets Y[N_GROUPS-1], i.e. after edge N_GROUPS·(D+1).
- ABORT at edge t: Y=0, BUSY=0, DONE=0 after edge t. A START at edge t+1 is accepted.
- RST mid-sequence: same effect as ABORT, and also clears dly_q.
- Maximum sequence length is N_GROUPS·2^DLY_W cycles.

## Structure
- The package gf180mcu_osu_sc_gp12t3v3__tie_rel_pkg holds:
  - the state enum (IDLE, COUNT, HELD);
  - the default N_GROUPS and DLY_W constants;
  - an idx-width function.
- Sub-module gf180mcu_osu_sc_gp12t3v3__tie_rel_cnt: loadable DLY_W down-counter with a load input, a decrement enable and a zero flag.
- The top level holds the FSM, idx and the Y register.
- Timing is functional only, with an empty specify block consistent with the library cells.

## Test plan
- Reset with N_GROUPS=4, DLY=3, START at edge 0 -> Y goes 0001, 0011, 0111, 1111 after edges 4, 8, 12, 16; DONE=1 and BUSY=0 after edge 16.
- DLY=0 -> Y[k] rises after edge k+1; DONE after edge 4.
- ABORT at edge 6 in the DLY=3 sequence (Y=0001) -> Y=0, BUSY=0 after edge 6. A new START at edge 7 with DLY=1 gives Y[0] after edge 9.
- START pulses and DLY changes at edges 2 and 5 during the DLY=3 sequence -> release edges unchanged (4, 8, 12, 16).
- RST asserted at edge 9 with START held high -> all outputs 0, dly_q=0. After RST drops, START at the next edge begins a fresh sequence.
- DLY=255, N_GROUPS=1 -> Y[0] and DONE rise after edge 256 with no counter wrap. ABORT and START in the same cycle in HELD -> IDLE, Y=0, no restart.
